width_12to8: RTL
================

Name: width_12to8

Overview:
- Data width converter, 12-bit words in, 8-bit bytes out.
- Two input words W0, W1 pack MSB-first into three output bytes:
  - B0 = W0[11:4]
  - B1 = {W0[3:0], W1[11:8]}
  - B2 = W1[7:0]
- Counterpart of the 8-to-12 packer. It sits on the transmit side of the same 8-bit byte stream.
- Full valid/ready handshake on both sides, with a registered output stage.

Parameters:
PAD_NIBBLE, 4'h0, fill nibble for the low half of a flushed byte (used only with the optional feature)

Ports:
clk        input   1   clock, rising edge
rst_n      input   1   reset, asynchronous, active-low
data_in    input   12  input word
valid_in   input   1   data_in valid
ready_in   output  1   block accepts data_in this cycle (combinational)
data_out   output  8   output byte (registered)
valid_out  output  1   data_out valid (registered)
ready_out  input   1   downstream accepts data_out this cycle

Behaviour:
- Definitions:
  - Input transfer = valid_in && ready_in.
  - Output transfer = valid_out && ready_out.
  - out_free = !valid_out || ready_out.
- State is phase P0/P4/P8, the number of residue bits held, plus residue register res[7:0].
- Reset, asynchronous:
  - phase = P0, res = 0
  - valid_out = 0, data_out = 8'h00
  - Reset mid-packet discards the residue and any undelivered output byte.
- ready_in:
  - = out_free in P0 and P4.
  - = 0 in P8.
  - Depends combinationally on ready_out.
- P0, on input transfer:
  - data_out <= W[11:4], valid_out <= 1
  - res[3:0] <= W[3:0]
  - go to P4
- P4, on input transfer:
  - data_out <= {res[3:0], W[11:8]}, valid_out <= 1
  - res <= W[7:0]
  - go to P8
- P8, when out_free:
  - data_out <= res, valid_out <= 1
  - go to P0
  - No input is accepted in this cycle.
- In any phase, out_free with no load that cycle: valid_out <= 0.
- While valid_out && !ready_out:
  - data_out and valid_out hold stable.
  - Phase and res hold.
- Latency: one cycle from input transfer to valid_out.
- Throughput with ready_out held high:
  - 2 words per 3 cycles.
  - valid_out continuously high while valid_in stays high.
- valid_in while ready_in = 0: the word is not taken. Upstream must hold data_in/valid_in stable until accepted.
- A lone word (P4, no further input) leaves W[3:0] in res indefinitely; no partial byte is ever emitted without the optional feature.
- No overflow or underflow is possible; backpressure is lossless.

Optional Feature:
- Macro: WIDTH_12TO8_FLUSH_EN.
- Defined:
  - Adds port flush, input, width 1, a level request to emit the residue.
  - In P4 with flush && out_free:
    - data_out <= {res[3:0], PAD_NIBBLE}, valid_out <= 1
    - go to P0
    - ready_in forced to 0 that cycle, so flush has priority over valid_in.
  - flush is ignored in P0 and P8; P8 drains by itself.
- Not defined:
  - No flush port.
  - A P4 residue is held until the next word arrives.

Test Plan:
- Reset then idle: valid_out = 0, data_out = 8'h00, ready_in = 1.
- Stream ABC, 123, 456, 789 with valid_in and ready_out held high:
  - Bytes AB, C1, 23, 45, 67, 89 on consecutive cycles.
  - ready_in low on the cycle after every second word.
- Backpressure: send ABC, 123 with ready_out = 0 for 3 cycles after the first valid_out:
  - data_out stays AB, ready_in stays 0.
  - Then C1, 23 follow with no loss or duplication.
- Random valid_in gaps and random ready_out over 1000 words: output byte stream equals the MSB-first serialisation of the input words.
- Reset asserted in P8 (after ABC, 123 accepted, before byte 23 is delivered):
  - valid_out drops immediately.
  - Next word 456 yields 45 first.
- With WIDTH_12TO8_FLUSH_EN, PAD_NIBBLE = 4'h0: send ABC, then assert flush with valid_in high on word 123:
  - Bytes AB, C0.
  - 123 is accepted after the flush and then yields 12.

Source files
------------

// File: rtl/width_12to8.sv
// 12-bit word to 8-bit byte packer, MSB-first, valid/ready on both sides with a registered output.
// Optional residue flush: define WIDTH_12TO8_FLUSH_EN to add the flush input.
module width_12to8 #(
    parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] data_in,
    input  logic        valid_in,
    output logic        ready_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_out
`ifdef WIDTH_12TO8_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P4 = 2'd1,
        P8 = 2'd2
    } phase_e;

    phase_e      phase_q, phase_d;
    logic [7:0]  res_q, res_d;
    logic [7:0]  dout_q, dout_d;
    logic        vout_q, vout_d;
    logic        out_free;
    logic        in_xfer;
    logic        flush_take;

    assign out_free = !vout_q || ready_out;

`ifdef WIDTH_12TO8_FLUSH_EN
    assign flush_take = (phase_q == P4) && flush && out_free;
`else
    assign flush_take = 1'b0;
`endif

    // A flush in P4 blocks input for that cycle so the residue leaves first.
    assign ready_in  = (phase_q != P8) && out_free && !flush_take;
    assign in_xfer   = valid_in && ready_in;
    assign data_out  = dout_q;
    assign valid_out = vout_q;

    always_comb begin
        phase_d = phase_q;
        res_d   = res_q;
        dout_d  = dout_q;
        vout_d  = vout_q;
        if (out_free) begin
            vout_d = 1'b0;
            unique case (phase_q)
                P0: begin
                    if (in_xfer) begin
                        dout_d  = data_in[11:4];
                        vout_d  = 1'b1;
                        // Upper residue nibble is dead in P4; filled only to keep it defined.
                        res_d   = {PAD_NIBBLE, data_in[3:0]};
                        phase_d = P4;
                    end
                end
                P4: begin
                    if (flush_take) begin
                        dout_d  = {res_q[3:0], PAD_NIBBLE};
                        vout_d  = 1'b1;
                        phase_d = P0;
                    end else if (in_xfer) begin
                        dout_d  = {res_q[3:0], data_in[11:8]};
                        vout_d  = 1'b1;
                        res_d   = data_in[7:0];
                        phase_d = P8;
                    end
                end
                P8: begin
                    dout_d  = res_q;
                    vout_d  = 1'b1;
                    phase_d = P0;
                end
                default: begin
                    phase_d = P0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= P0;
            res_q   <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            res_q   <= res_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
        end
    end

endmodule
